// File: rtl/vlog_lex_stream.sv
// Streaming Verilog tokeniser: one byte in, one classified token out, valid/ready on both sides.
// Optional macro VLOG_LEX_SHIFT3_EN extends << / >> to the three-character shifts <<< / >>>.
module vlog_lex_stream #(
  parameter int HASH_W = 32,
  parameter int LINE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [2:0]        tok_kind,
  output logic [HASH_W-1:0] tok_value,
  output logic [7:0]        tok_len,
  output logic [LINE_W-1:0] tok_line
);

  typedef enum logic [3:0] {
    S_IDLE, S_IDENT, S_SYS, S_NUM, S_STR, S_STR_ESC, S_SLASH,
    S_LCOM, S_BCOM, S_BSTAR, S_OPC, S_DONE, S_SH3
  } state_e;

  localparam logic [2:0] K_EOF = 3'd0, K_IDENT = 3'd1, K_SYS = 3'd2, K_NUM = 3'd3;
  localparam logic [2:0] K_STR = 3'd4, K_OP1 = 3'd5, K_OP2 = 3'd6, K_ERR = 3'd7;

  function automatic logic is_alpha(input logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_";
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A;
  endfunction

  function automatic logic is_ident_cont(input logic [7:0] c);
    return is_alpha(c) || is_digit(c) || c == "$";
  endfunction

  function automatic logic is_opc(input logic [7:0] c);
    return c == "<" || c == ">" || c == "=" || c == "!" || c == "&" ||
           c == "|" || c == "+" || c == "-" || c == "*";
  endfunction

  // Doubled operators (except !!) plus the three compare-with-= forms.
  function automatic logic is_pair(input logic [7:0] a, input logic [7:0] c);
    return (a == c && a != "!") || (c == "=" && (a == "<" || a == ">" || a == "!"));
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] n);
    return (n == 8'd255) ? n : n + 8'd1;
  endfunction

  function automatic logic [HASH_W-1:0] op_val(input logic [7:0] a, input logic [7:0] c,
                                               input logic [7:0] e);
    return HASH_W'({a, c, e});
  endfunction

  function automatic logic [HASH_W-1:0] hash_step(input logic [HASH_W-1:0] h,
                                                  input logic [7:0] c);
    return h * HASH_W'(31) + HASH_W'(c);
  endfunction

  function automatic logic [HASH_W-1:0] num_step(input logic [HASH_W-1:0] v,
                                                 input logic [7:0] c);
    return v * HASH_W'(10) + HASH_W'(c - 8'd48);
  endfunction

  // Whether the current state swallows byte c or leaves it for IDLE to re-examine.
  function automatic logic byte_taken(input state_e st, input logic [7:0] c,
                                      input logic [7:0] a);
    logic t;
    t = 1'b0;
    case (st)
      S_IDLE:                                    t = 1'b1;
      S_IDENT, S_SYS:                            t = is_ident_cont(c);
      S_NUM:                                     t = is_digit(c) || c == "_";
      S_STR, S_STR_ESC, S_LCOM, S_BCOM, S_BSTAR: t = (c != 8'h00);
      S_SLASH:                                   t = (c == "/" || c == "*");
      S_OPC:                                     t = is_pair(a, c);
      S_SH3:                                     t = (c == a);
      default:                                   t = 1'b0;
    endcase
    return t;
  endfunction

  state_e              state_q, state_d;
  logic [HASH_W-1:0]   acc_q, acc_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          c1_q, c1_d;
  logic [LINE_W-1:0]   sline_q, sline_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                tok_valid_q, tok_valid_d;
  logic [2:0]          tok_kind_q, tok_kind_d;
  logic [HASH_W-1:0]   tok_value_q, tok_value_d;
  logic [7:0]          tok_len_q, tok_len_d;
  logic [LINE_W-1:0]   tok_line_q, tok_line_d;

  logic                emit, ext3;
  logic [2:0]          ek;
  logic [HASH_W-1:0]   ev;
  logic [7:0]          el;
  logic [LINE_W-1:0]   eline;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_q      <= LINE_W'(1);
      tok_valid_q <= 1'b0;
      tok_kind_q  <= K_EOF;
      tok_value_q <= '0;
      tok_len_q   <= 8'd0;
      tok_line_q  <= LINE_W'(1);
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      tok_valid_q <= tok_valid_d;
      tok_kind_q  <= tok_kind_d;
      tok_value_q <= tok_value_d;
      tok_len_q   <= tok_len_d;
      tok_line_q  <= tok_line_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    len_q   <= len_d;
    c1_q    <= c1_d;
    sline_q <= sline_d;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    len_d       = len_q;
    c1_d        = c1_q;
    sline_d     = sline_q;
    line_d      = line_q;
    tok_valid_d = tok_valid_q;
    tok_kind_d  = tok_kind_q;
    tok_value_d = tok_value_q;
    tok_len_d   = tok_len_q;
    tok_line_d  = tok_line_q;
    emit        = 1'b0;
    ek          = K_EOF;
    ev          = '0;
    el          = 8'd0;
    eline       = line_q;
    ext3        = 1'b0;
`ifdef VLOG_LEX_SHIFT3_EN
    ext3 = (ch_data == c1_q) && (ch_data == "<" || ch_data == ">");
`endif

    if (ch_valid && ch_ready && ch_data == 8'h0A) line_d = line_q + LINE_W'(1);
    if (tok_valid_q && tok_ready) tok_valid_d = 1'b0;

    // Terminators that are not consumed still close the token; the byte waits for IDLE.
    if (ch_valid && !tok_valid_q) begin
      unique case (state_q)
        S_IDLE: begin
          sline_d = line_q;
          len_d   = 8'd1;
          c1_d    = ch_data;
          if (is_ws(ch_data)) begin
          end else if (is_alpha(ch_data)) begin
            state_d = S_IDENT;
            acc_d   = HASH_W'(ch_data);
          end else if (ch_data == "$") begin
            state_d = S_SYS;
            acc_d   = '0;
          end else if (is_digit(ch_data)) begin
            state_d = S_NUM;
            acc_d   = HASH_W'(ch_data - 8'd48);
          end else if (ch_data == 8'h22) begin
            state_d = S_STR;
            acc_d   = '0;
          end else if (ch_data == "/") begin
            state_d = S_SLASH;
          end else if (is_opc(ch_data)) begin
            state_d = S_OPC;
          end else if (ch_data == 8'h00) begin
            state_d = S_DONE;
            emit    = 1'b1;
          end else if (ch_data >= 8'h21 && ch_data <= 8'h7E) begin
            emit = 1'b1; ek = K_OP1; ev = op_val(8'h00, ch_data, 8'h00); el = 8'd1;
          end else begin
            emit = 1'b1; ek = K_ERR; el = 8'd1;
          end
        end
        S_IDENT, S_SYS: begin
          if (is_ident_cont(ch_data)) begin
            acc_d = hash_step(acc_q, ch_data);
            len_d = sat_inc(len_q);
          end else begin
            state_d = S_IDLE;
            emit    = 1'b1;
            eline   = sline_q;
            if (state_q == S_SYS && len_q == 8'd1) begin
              ek = K_ERR; el = 8'd1;
            end else begin
              ek = (state_q == S_SYS) ? K_SYS : K_IDENT; ev = acc_q; el = len_q;
            end
          end
        end
        S_NUM: begin
          if (is_digit(ch_data)) begin
            acc_d = num_step(acc_q, ch_data);
            len_d = sat_inc(len_q);
          end else if (ch_data == "_") begin
            len_d = sat_inc(len_q);
          end else begin
            state_d = S_IDLE;
            emit = 1'b1; ek = K_NUM; ev = acc_q; el = len_q; eline = sline_q;
          end
        end
        S_STR, S_STR_ESC: begin
          len_d = sat_inc(len_q);
          if (ch_data == 8'h00) begin
            state_d = S_IDLE;
            emit = 1'b1; ek = K_ERR; el = 8'd1;
          end else if (state_q == S_STR_ESC) begin
            state_d = S_STR;
            acc_d   = hash_step(acc_q, ch_data);
          end else if (ch_data == 8'h22) begin
            state_d = S_IDLE;
            emit = 1'b1; ek = K_STR; ev = acc_q; el = sat_inc(len_q); eline = sline_q;
          end else if (ch_data == 8'h5C) begin
            state_d = S_STR_ESC;
          end else begin
            acc_d = hash_step(acc_q, ch_data);
          end
        end
        S_SLASH: begin
          if (ch_data == "/") state_d = S_LCOM;
          else if (ch_data == "*") state_d = S_BCOM;
          else begin
            state_d = S_IDLE;
            emit = 1'b1; ek = K_OP1; ev = op_val(8'h00, "/", 8'h00); el = 8'd1; eline = sline_q;
          end
        end
        S_LCOM: begin
          if (ch_data == 8'h00 || ch_data == 8'h0A) state_d = S_IDLE;
        end
        S_BCOM, S_BSTAR: begin
          if (ch_data == 8'h00) begin
            state_d = S_IDLE;
            emit = 1'b1; ek = K_ERR; el = 8'd1;
          end else if (ch_data == "*") state_d = S_BSTAR;
          else if (state_q == S_BSTAR && ch_data == "/") state_d = S_IDLE;
          else state_d = S_BCOM;
        end
        S_OPC: begin
          state_d = S_IDLE;
          eline   = sline_q;
          if (is_pair(c1_q, ch_data)) begin
            if (ext3) state_d = S_SH3;
            else begin
              emit = 1'b1; ek = K_OP2; ev = op_val(8'h00, c1_q, ch_data); el = 8'd2;
            end
          end else begin
            emit = 1'b1; ek = K_OP1; ev = op_val(8'h00, c1_q, 8'h00); el = 8'd1;
          end
        end
`ifdef VLOG_LEX_SHIFT3_EN
        S_SH3: begin
          state_d = S_IDLE;
          emit = 1'b1; ek = K_OP2; eline = sline_q;
          if (ch_data == c1_q) begin
            ev = op_val(c1_q, c1_q, c1_q); el = 8'd3;
          end else begin
            ev = op_val(8'h00, c1_q, c1_q); el = 8'd2;
          end
        end
`endif
        S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (emit) begin
      tok_valid_d = 1'b1;
      tok_kind_d  = ek;
      tok_value_d = ev;
      tok_len_d   = el;
      tok_line_d  = eline;
    end
  end

  always_comb begin
    ch_ready = 1'b0;
    if (!rst && !tok_valid_q && state_q != S_DONE)
      ch_ready = byte_taken(state_q, ch_data, c1_q);
  end

  assign tok_valid = tok_valid_q;
  assign tok_kind  = tok_kind_q;
  assign tok_value = tok_value_q;
  assign tok_len   = tok_len_q;
  assign tok_line  = tok_line_q;

endmodule

// File: tb/tb_vlog_lex_stream.sv
// Directed bench for vlog_lex_stream: byte streams in, token sequences compared to hand-derived tables.
module tb_vlog_lex_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic        tok_valid;
  logic        tok_ready = 1'b1;
  logic [2:0]  tok_kind;
  logic [31:0] tok_value;
  logic [7:0]  tok_len;
  logic [15:0] tok_line;

  int checks = 0;
  int fails  = 0;

  logic [2:0]  tk  [16];
  logic [31:0] tvl [16];
  logic [7:0]  tln [16];
  logic [15:0] tli [16];
  int          ntok;

  vlog_lex_stream #(.HASH_W(32), .LINE_W(16)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind),
    .tok_value(tok_value), .tok_len(tok_len), .tok_line(tok_line)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ch_valid = 1'b0; tok_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams s (plus a 0x00 terminator when add_eof) and records every token seen.
  task automatic feed(input string s, input bit add_eof, output bit done);
    int n, idx, cyc;
    bit rdy, tv;
    n = s.len() + (add_eof ? 1 : 0);
    idx = 0; cyc = 0; ntok = 0; done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tk[i] = 'x; tvl[i] = 'x; tln[i] = 'x; tli[i] = 'x;
    end
    tok_ready = 1'b1;
    while (cyc < 400 && !done) begin
      @(negedge clk);
      if (idx < n) begin
        ch_valid = 1'b1;
        ch_data  = (idx < s.len()) ? s[idx] : 8'h00;
      end else begin
        ch_valid = 1'b0;
        ch_data  = 8'h00;
      end
      #1;
      rdy = ch_ready;
      tv  = tok_valid;
      if (tv && ntok < 16) begin
        tk[ntok] = tok_kind; tvl[ntok] = tok_value; tln[ntok] = tok_len; tli[ntok] = tok_line;
        ntok++;
      end
      if (add_eof && tv && tok_kind == 3'd0) done = 1'b1;
      if (!add_eof && idx >= n && !tv) done = 1'b1;
      @(posedge clk);
      if (ch_valid && rdy) idx++;
      cyc++;
    end
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ch_valid = 1'b1; ch_data = "a"; tok_ready = 1'b1;
    #1;
    checks++; if (ch_ready !== 1'b0) begin fails++; $display("FAIL reset_ch_ready_in_rst: got %b expected 0", ch_ready); end
    @(negedge clk); #1;
    checks++; if (tok_valid !== 1'b0) begin fails++; $display("FAIL reset_tok_valid: got %b expected 0", tok_valid); end
    checks++; if (tok_kind !== 3'd0) begin fails++; $display("FAIL reset_tok_kind: got %0d expected 0", tok_kind); end
    checks++; if (tok_value !== 32'd0) begin fails++; $display("FAIL reset_tok_value: got %h expected 0", tok_value); end
    checks++; if (tok_len !== 8'd0) begin fails++; $display("FAIL reset_tok_len: got %0d expected 0", tok_len); end
    checks++; if (tok_line !== 16'd1) begin fails++; $display("FAIL reset_tok_line: got %0d expected 1", tok_line); end
    rst = 1'b0; ch_valid = 1'b0;
    #1;
    checks++; if (ch_ready !== 1'b1) begin fails++; $display("FAIL reset_idle_ready: got %b expected 1", ch_ready); end
  endtask

  task automatic test_ident_ops();
    bit done;
    logic [2:0]  ek [5] = '{3'd1, 3'd5, 3'd1, 3'd5, 3'd0};
    logic [31:0] ev [5] = '{32'd120, 32'h3D00, 32'd121, 32'h3B00, 32'd0};
    logic [7:0]  el [5] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0};
    do_reset();
    feed("x = y;", 1'b1, done);
    checks++; if (!done || ntok !== 5) begin fails++; $display("FAIL ident_count: got %0d tokens (eof %0b) expected 5", ntok, done); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tk[i] !== ek[i] || tvl[i] !== ev[i] || tln[i] !== el[i] || tli[i] !== 16'd1) begin
        fails++;
        $display("FAIL ident_tok%0d: got kind %0d value %h len %0d line %0d, expected kind %0d value %h len %0d line 1",
                 i, tk[i], tvl[i], tln[i], tli[i], ek[i], ev[i], el[i]);
      end
    end
  endtask

  task automatic test_systask_string();
    bit done;
    logic [2:0]  ek [5] = '{3'd2, 3'd5, 3'd4, 3'd5, 3'd0};
    logic [31:0] ev [5] = '{32'd1671764162, 32'h2800, 32'd3329, 32'h2900, 32'd0};
    logic [7:0]  el [5] = '{8'd8, 8'd1, 8'd4, 8'd1, 8'd0};
    do_reset();
    feed("$display(\"hi\")", 1'b1, done);
    checks++; if (!done || ntok !== 5) begin fails++; $display("FAIL systask_count: got %0d tokens (eof %0b) expected 5", ntok, done); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tk[i] !== ek[i] || tvl[i] !== ev[i] || tln[i] !== el[i] || tli[i] !== 16'd1) begin
        fails++;
        $display("FAIL systask_tok%0d: got kind %0d value %h len %0d line %0d, expected kind %0d value %h len %0d line 1",
                 i, tk[i], tvl[i], tln[i], tli[i], ek[i], ev[i], el[i]);
      end
    end
  endtask

  task automatic test_sys_error();
    bit done;
    logic [2:0]  ek [3] = '{3'd7, 3'd5, 3'd0};
    logic [31:0] ev [3] = '{32'd0, 32'h3B00, 32'd0};
    logic [7:0]  el [3] = '{8'd1, 8'd1, 8'd0};
    do_reset();
    feed("$;", 1'b1, done);
    checks++; if (!done || ntok !== 3) begin fails++; $display("FAIL syserr_count: got %0d tokens (eof %0b) expected 3", ntok, done); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tk[i] !== ek[i] || tvl[i] !== ev[i] || tln[i] !== el[i]) begin
        fails++;
        $display("FAIL syserr_tok%0d: got kind %0d value %h len %0d, expected kind %0d value %h len %0d",
                 i, tk[i], tvl[i], tln[i], ek[i], ev[i], el[i]);
      end
    end
  endtask

  task automatic test_number_comment();
    bit done;
    logic [2:0]  ek [3] = '{3'd3, 3'd3, 3'd0};
    logic [31:0] ev [3] = '{32'd1000, 32'd42, 32'd0};
    logic [7:0]  el [3] = '{8'd5, 8'd2, 8'd0};
    logic [15:0] eli[3] = '{16'd1, 16'd2, 16'd2};
    do_reset();
    feed("1_000 // c\n42", 1'b1, done);
    checks++; if (!done || ntok !== 3) begin fails++; $display("FAIL number_count: got %0d tokens (eof %0b) expected 3", ntok, done); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tk[i] !== ek[i] || tvl[i] !== ev[i] || tln[i] !== el[i] || tli[i] !== eli[i]) begin
        fails++;
        $display("FAIL number_tok%0d: got kind %0d value %0d len %0d line %0d, expected kind %0d value %0d len %0d line %0d",
                 i, tk[i], tvl[i], tln[i], tli[i], ek[i], ev[i], el[i], eli[i]);
      end
    end
  endtask

  task automatic test_shift_ops();
    bit done;
`ifdef VLOG_LEX_SHIFT3_EN
    localparam int N = 6;
    logic [2:0]  ek [N] = '{3'd1, 3'd6, 3'd1, 3'd6, 3'd1, 3'd0};
    logic [31:0] ev [N] = '{32'd97, 32'h3C3D, 32'd98, 32'h3C3C3C, 32'd99, 32'd0};
    logic [7:0]  el [N] = '{8'd1, 8'd2, 8'd1, 8'd3, 8'd1, 8'd0};
`else
    localparam int N = 7;
    logic [2:0]  ek [N] = '{3'd1, 3'd6, 3'd1, 3'd6, 3'd5, 3'd1, 3'd0};
    logic [31:0] ev [N] = '{32'd97, 32'h3C3D, 32'd98, 32'h3C3C, 32'h3C00, 32'd99, 32'd0};
    logic [7:0]  el [N] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd0};
`endif
    do_reset();
    feed("a<=b<<<c", 1'b1, done);
    checks++; if (!done || ntok !== N) begin fails++; $display("FAIL shift_count: got %0d tokens (eof %0b) expected %0d", ntok, done, N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (tk[i] !== ek[i] || tvl[i] !== ev[i] || tln[i] !== el[i]) begin
        fails++;
        $display("FAIL shift_tok%0d: got kind %0d value %h len %0d, expected kind %0d value %h len %0d",
                 i, tk[i], tvl[i], tln[i], ek[i], ev[i], el[i]);
      end
    end
  endtask

  task automatic test_bcom_eof_stall();
    string s = "/* x\n";
    int not_ready = 0;
    int bad = 0;
    do_reset();
    tok_ready = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ch_valid = 1'b1; ch_data = s[i];
      #1;
      if (ch_ready !== 1'b1) not_ready++;
    end
    checks++; if (not_ready !== 0) begin fails++; $display("FAIL bcom_consume: got %0d stalled bytes expected 0", not_ready); end
    @(negedge clk);
    ch_data = 8'h00;
    #1;
    checks++; if (ch_ready !== 1'b0) begin fails++; $display("FAIL bcom_nul_not_taken: got ch_ready %b expected 0", ch_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (tok_valid !== 1'b1 || tok_kind !== 3'd7 || tok_line !== 16'd2 || tok_len !== 8'd1 || ch_ready !== 1'b0) begin
        bad++;
        $display("FAIL bcom_stall_cycle%0d: got valid %b kind %0d line %0d len %0d ready %b, expected 1 7 2 1 0",
                 k, tok_valid, tok_kind, tok_line, tok_len, ch_ready);
      end
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL bcom_stall: got %0d bad cycles expected 0", bad); end
    tok_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (tok_valid !== 1'b0 || ch_ready !== 1'b1) begin fails++; $display("FAIL bcom_after_accept: got valid %b ready %b expected 0 1", tok_valid, ch_ready); end
    @(negedge clk); #1;
    checks++; if (tok_valid !== 1'b1 || tok_kind !== 3'd0 || tok_line !== 16'd2) begin fails++; $display("FAIL bcom_eof: got valid %b kind %0d line %0d expected 1 0 2", tok_valid, tok_kind, tok_line); end
    @(negedge clk); #1;
    checks++; if (tok_valid !== 1'b0 || ch_ready !== 1'b0) begin fails++; $display("FAIL bcom_done: got valid %b ready %b expected 0 0", tok_valid, ch_ready); end
    ch_valid = 1'b0;
  endtask

  task automatic test_reset_mid_string();
    bit done;
    do_reset();
    feed("\"a\nb", 1'b0, done);
    checks++; if (!done || ntok !== 0) begin fails++; $display("FAIL midstr_no_token: got %0d tokens (fed %0b) expected 0", ntok, done); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (tok_valid !== 1'b0 || tok_line !== 16'd1) begin fails++; $display("FAIL midstr_reset: got valid %b line %0d expected 0 1", tok_valid, tok_line); end
    rst = 1'b0;
    feed("z", 1'b1, done);
    checks++; if (!done || ntok !== 2) begin fails++; $display("FAIL midstr_count: got %0d tokens (eof %0b) expected 2", ntok, done); end
    checks++; if (tk[0] !== 3'd1 || tvl[0] !== 32'd122 || tln[0] !== 8'd1 || tli[0] !== 16'd1) begin
      fails++; $display("FAIL midstr_ident: got kind %0d value %0d len %0d line %0d expected 1 122 1 1", tk[0], tvl[0], tln[0], tli[0]);
    end
    checks++; if (tk[1] !== 3'd0 || tli[1] !== 16'd1) begin fails++; $display("FAIL midstr_eof: got kind %0d line %0d expected 0 1", tk[1], tli[1]); end
  endtask

  initial begin
    test_reset();
    test_ident_ops();
    test_systask_string();
    test_sys_error();
    test_number_comment();
    test_shift_ops();
    test_bcom_eof_stall();
    test_reset_mid_string();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
